// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for N_SRC sources sharing one WIDTH-bit bus.
// A source may keep its grant with src_lock for at most MAX_HOLD cycles.
// Optional feature macro: BUS_ARBITER_STATS_EN adds a saturating
// contention_count output (cycles with two or more requesters).
module bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N_SRC    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC-1:0]       src_lock,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]       src_grant,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
`ifdef BUS_ARBITER_STATS_EN
  output logic [15:0]            contention_count,
`endif
  output logic [7:0]             hold_count
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           state_r;
  logic [N_SRC-1:0] grant_r;
  logic [7:0]       hold_r;
  logic [PW-1:0]    rr_ptr_r;

  logic             own_req_s;
  logic             own_lock_s;
  logic             at_limit_s;
  logic             release_s;
  logic             forced_s;
  logic [N_SRC-1:0] others_s;
  logic [N_SRC-1:0] cand_s;
  logic [N_SRC-1:0] pick_s;
  logic [PW-1:0]    pick_ptr_s;
  logic [WIDTH-1:0] bus_s;

  // Rotate candidates so rr_ptr sits at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into source order.
  function automatic logic [N_SRC-1:0] rr_pick(input logic [N_SRC-1:0] cand,
                                               input logic [PW-1:0]    ptr);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    logic [N_SRC-1:0]   first;
    logic               found;
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[N_SRC-1:0];
    first = {N_SRC{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && rot[i]) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    dbl = {first, first} << ptr;
    return dbl[2*N_SRC-1:N_SRC];
  endfunction

  // Pointer that follows a one-hot winner, wrapping N_SRC-1 back to 0.
  function automatic logic [PW-1:0] next_ptr(input logic [N_SRC-1:0] onehot);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      if (onehot[i]) begin
        p = (i == N_SRC - 1) ? {PW{1'b0}} : PW'(i + 1);
      end
    end
    return p;
  endfunction

  // Release decision for the current owner and the candidate set for re-arbitration.
  always_comb begin
    own_req_s  = |(src_req & grant_r);
    own_lock_s = |(src_lock & grant_r);
    at_limit_s = (hold_r == 8'(MAX_HOLD - 1));
    release_s  = (state_r == ST_OWNED) && (!own_req_s || !own_lock_s || at_limit_s);
    forced_s   = (state_r == ST_OWNED) && own_req_s && own_lock_s && at_limit_s;
    others_s   = src_req & ~grant_r;
    if (forced_s && (|others_s)) begin
      cand_s = others_s;
    end else begin
      cand_s = src_req;
    end
    pick_s     = rr_pick(cand_s, rr_ptr_r);
    pick_ptr_s = next_ptr(pick_s);
  end

  // Arbitration FSM: owner, hold counter and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      grant_r  <= {N_SRC{1'b0}};
      hold_r   <= 8'd0;
      rr_ptr_r <= {PW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          hold_r <= 8'd0;
          if (|src_req) begin
            grant_r  <= pick_s;
            rr_ptr_r <= pick_ptr_s;
            state_r  <= ST_OWNED;
          end else begin
            grant_r <= {N_SRC{1'b0}};
          end
        end
        ST_OWNED: begin
          if (release_s) begin
            hold_r <= 8'd0;
            if (|cand_s) begin
              grant_r  <= pick_s;
              rr_ptr_r <= pick_ptr_s;
            end else begin
              grant_r <= {N_SRC{1'b0}};
              state_r <= ST_IDLE;
            end
          end else begin
            hold_r <= hold_r + 8'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          grant_r  <= {N_SRC{1'b0}};
          hold_r   <= 8'd0;
          rr_ptr_r <= {PW{1'b0}};
        end
      endcase
    end
  end

  // Bus mux driven from the registered grant; zero when nobody owns the bus.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_r[i]) begin
        bus_s = bus_s | src_data[i*WIDTH +: WIDTH];
      end else begin
        bus_s = bus_s;
      end
    end
  end

  assign src_grant  = grant_r;
  assign hold_count = hold_r;
  assign bus        = bus_s;
  assign bus_valid  = |grant_r;

`ifdef BUS_ARBITER_STATS_EN
  logic [15:0] contention_r;
  logic        contended_s;

  // Number of set bits in a request vector (N_SRC <= 8 fits in 4 bits).
  function automatic logic [3:0] count_ones(input logic [N_SRC-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < N_SRC; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  assign contended_s = (count_ones(src_req) >= 4'd2);

  // Saturating count of cycles with two or more simultaneous requesters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      contention_r <= 16'd0;
    end else if (contended_s && (contention_r != 16'hFFFF)) begin
      contention_r <= contention_r + 16'd1;
    end
  end

  assign contention_count = contention_r;
`endif

endmodule
